// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line coordinates and lock status from incoming VGA syncs.
// Optional VGA_SYNC_STATS_EN adds a saturating lock-loss counter err_count.
module vga_sync_decoder #(
  parameter int H_VISIBLE       = 640,
  parameter int H_SYNC_START    = 656,
  parameter int H_TOTAL         = 800,
  parameter int V_VISIBLE       = 480,
  parameter int V_SYNC_START    = 490,
  parameter int V_TOTAL         = 525,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_LINES      = 4
) (
  input  logic        clk25MHz,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        vsync,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic        active_video,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked
`ifdef VGA_SYNC_STATS_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam logic ACT = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic [15:0] HV  = 16'(H_VISIBLE);
  localparam logic [15:0] HSS = 16'(H_SYNC_START);
  localparam logic [15:0] HT  = 16'(H_TOTAL);
  localparam logic [15:0] VV  = 16'(V_VISIBLE);
  localparam logic [15:0] VSS = 16'(V_SYNC_START);
  localparam logic [15:0] VT  = 16'(V_TOTAL);
  localparam logic [15:0] LMX = 16'(2 * H_TOTAL);
  localparam logic [7:0]  LL  = 8'(LOCK_LINES);

  typedef enum logic {
    UNLOCKED,
    H_LOCKED
  } state_t;

  state_t      state, state_nx;
  logic        hs_s1, hs_s2, vs_s1, vs_s2;
  logic        hs_edge, vs_edge, h_wrap;
  logic        bad_line, timeout;
  logic [15:0] x_nx, y_nx;
  logic [15:0] len, len_nx;
  logic [15:0] line_cnt, line_cnt_nx, lc_hs;
  logic [7:0]  good, good_nx;
  logic        v_valid, v_valid_nx;
  logic        v_armed, v_armed_nx;
  logic        locked_nx;

  always_comb begin
    hs_edge  = (hs_s1 == ACT) && (hs_s2 != ACT);
    vs_edge  = (vs_s1 == ACT) && (vs_s2 != ACT);
    h_wrap   = (pixel_x == HT - 16'd1);

    x_nx = pixel_x + 16'd1;
    if (hs_edge)     x_nx = HSS;
    else if (h_wrap) x_nx = 16'd0;

    y_nx = pixel_y;
    if (vs_edge)
      y_nx = VSS;
    else if (!hs_edge && h_wrap)
      y_nx = (pixel_y == VT - 16'd1) ? 16'd0 : pixel_y + 16'd1;

    // timeout fires once, on the cycle len saturates
    len_nx = (len == LMX) ? len : len + 16'd1;
    if (hs_edge) len_nx = 16'd1;
    timeout  = !hs_edge && (len == LMX - 16'd1);
    bad_line = hs_edge && (len != HT);

    good_nx = good;
    if (bad_line || timeout)
      good_nx = 8'd0;
    else if (hs_edge && good != LL)
      good_nx = good + 8'd1;

    state_nx = state;
    unique case (state)
      UNLOCKED: if (good_nx == LL) state_nx = H_LOCKED;
      H_LOCKED: if (bad_line || timeout) state_nx = UNLOCKED;
      default:  state_nx = UNLOCKED;
    endcase

    lc_hs = line_cnt;
    if (hs_edge && line_cnt != 16'hFFFF) lc_hs = line_cnt + 16'd1;
    line_cnt_nx = vs_edge ? 16'd0 : lc_hs;

    // first vsync after horizontal lock only arms the frame check
    v_valid_nx = v_valid;
    v_armed_nx = v_armed;
    if (state == H_LOCKED && vs_edge) begin
      if (v_armed) v_valid_nx = (lc_hs == VT);
      v_armed_nx = 1'b1;
    end
    if (state_nx != H_LOCKED) begin
      v_valid_nx = 1'b0;
      v_armed_nx = 1'b0;
    end

    locked_nx = (state_nx == H_LOCKED) && v_valid_nx;
  end

  always_ff @(posedge clk25MHz or negedge reset_n) begin
    if (!reset_n) begin
      hs_s1        <= ~ACT;
      hs_s2        <= ~ACT;
      vs_s1        <= ~ACT;
      vs_s2        <= ~ACT;
      pixel_x      <= 16'd0;
      pixel_y      <= 16'd0;
      len          <= 16'd0;
      good         <= 8'd0;
      line_cnt     <= 16'd0;
      state        <= UNLOCKED;
      v_valid      <= 1'b0;
      v_armed      <= 1'b0;
      locked       <= 1'b0;
      active_video <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      hs_s1        <= hsync;
      hs_s2        <= hs_s1;
      vs_s1        <= vsync;
      vs_s2        <= vs_s1;
      pixel_x      <= x_nx;
      pixel_y      <= y_nx;
      len          <= len_nx;
      good         <= good_nx;
      line_cnt     <= line_cnt_nx;
      state        <= state_nx;
      v_valid      <= v_valid_nx;
      v_armed      <= v_armed_nx;
      locked       <= locked_nx;
      active_video <= locked_nx && (x_nx < HV) && (y_nx < VV);
      line_start   <= (x_nx == 16'd0);
      frame_start  <= (x_nx == 16'd0) && (y_nx == 16'd0);
    end
  end

`ifdef VGA_SYNC_STATS_EN
  logic err_ev;

  // simultaneous h-lock loss and v_valid drop count once
  assign err_ev = (state == H_LOCKED && state_nx == UNLOCKED)
               || (v_valid && !v_valid_nx);

  always_ff @(posedge clk25MHz or negedge reset_n) begin
    if (!reset_n)
      err_count <= 16'd0;
    else if (err_ev && err_count != 16'hFFFF)
      err_count <= err_count + 16'd1;
  end
`endif

endmodule
